axis_byte_packer: RTL and testbench

AXIS_BYTE_PACKER -- requirements
Module: axis_byte_packer

---
 rtl/axis_byte_packer_if.sv | 23 ++
 rtl/axis_byte_packer.sv | 125 ++++++++++++
 tb/tb_axis_byte_packer.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/axis_byte_packer_if.sv
// Byte-in / 32-bit-word-out stream bundle for axis_byte_packer.
// master = upstream source plus downstream sink; slave = the packer.
interface axis_byte_packer_if;
    logic [7:0]  input_tdata;
    logic        input_tvalid;
    logic        input_tlast;
    logic        input_tready;
    logic [31:0] output_tdata;
    logic [3:0]  output_tkeep;
    logic        output_tvalid;
    logic        output_tlast;
    logic        output_tready;

    modport master (
        output input_tdata, input_tvalid, input_tlast, output_tready,
        input  input_tready, output_tdata, output_tkeep, output_tvalid, output_tlast
    );

    modport slave (
        input  input_tdata, input_tvalid, input_tlast, output_tready,
        output input_tready, output_tdata, output_tkeep, output_tvalid, output_tlast
    );
endinterface

// File: rtl/axis_byte_packer.sv
// Packs an 8-bit stream into 32-bit words with tkeep, padding short tails with PAD_VALUE.
// Optional AXIS_PACKER_STATS_EN adds packet and byte counters on transferred words.
module axis_byte_packer #(
    parameter logic [7:0] PAD_VALUE = 8'h00
) (
    input  logic               clk,
    input  logic               reset,
    axis_byte_packer_if.slave  bus
`ifdef AXIS_PACKER_STATS_EN
    ,
    output logic [15:0]        stat_pkt_count,
    output logic [31:0]        stat_byte_count
`endif
);

    logic [1:0]       lane_cnt_q, lane_cnt_d;
    logic [2:0][7:0]  acc_q, acc_d;
    logic [31:0]      tdata_q, tdata_d;
    logic [3:0]       tkeep_q, tkeep_d;
    logic             tvalid_q, tvalid_d;
    logic             tlast_q, tlast_d;

    logic             in_ready;
    logic             accept;
    logic             complete;
    logic             xfer;
    logic [31:0]      word;
    logic [3:0]       keep;

    assign in_ready = !reset && (!tvalid_q || bus.output_tready);
    assign accept   = bus.input_tvalid && in_ready;
    assign complete = accept && ((lane_cnt_q == 2'd3) || bus.input_tlast);
    assign xfer     = tvalid_q && bus.output_tready;

    // Assembled word: stored lanes below lane_cnt, the incoming byte at lane_cnt, pad above.
    always_comb begin
        word = {4{PAD_VALUE}};
        keep = 4'h0;
        for (int i = 0; i < 3; i++) begin
            if (2'(i) < lane_cnt_q) word[8*i +: 8] = acc_q[i];
        end
        word[{lane_cnt_q, 3'b000} +: 8] = bus.input_tdata;
        for (int i = 0; i < 4; i++) begin
            keep[i] = (2'(i) <= lane_cnt_q);
        end
    end

    always_comb begin
        lane_cnt_d = lane_cnt_q;
        acc_d      = acc_q;
        tdata_d    = tdata_q;
        tkeep_d    = tkeep_q;
        tvalid_d   = tvalid_q;
        tlast_d    = tlast_q;

        if (xfer) tvalid_d = 1'b0;

        if (complete) begin
            tdata_d    = word;
            tkeep_d    = keep;
            tlast_d    = bus.input_tlast;
            tvalid_d   = 1'b1;
            lane_cnt_d = 2'd0;
        end else if (accept) begin
            case (lane_cnt_q)
                2'd0:    acc_d[0] = bus.input_tdata;
                2'd1:    acc_d[1] = bus.input_tdata;
                default: acc_d[2] = bus.input_tdata;
            endcase
            lane_cnt_d = lane_cnt_q + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lane_cnt_q <= 2'd0;
            acc_q      <= '0;
            tdata_q    <= 32'h0;
            tkeep_q    <= 4'h0;
            tvalid_q   <= 1'b0;
            tlast_q    <= 1'b0;
        end else begin
            lane_cnt_q <= lane_cnt_d;
            acc_q      <= acc_d;
            tdata_q    <= tdata_d;
            tkeep_q    <= tkeep_d;
            tvalid_q   <= tvalid_d;
            tlast_q    <= tlast_d;
        end
    end

    assign bus.input_tready  = in_ready;
    assign bus.output_tdata  = tdata_q;
    assign bus.output_tkeep  = tkeep_q;
    assign bus.output_tvalid = tvalid_q;
    assign bus.output_tlast  = tlast_q;

`ifdef AXIS_PACKER_STATS_EN
    logic [15:0] pkt_cnt_q, pkt_cnt_d;
    logic [31:0] byte_cnt_q, byte_cnt_d;

    always_comb begin
        pkt_cnt_d  = pkt_cnt_q;
        byte_cnt_d = byte_cnt_q;
        if (xfer) begin
            pkt_cnt_d  = pkt_cnt_q + 16'(tlast_q);
            byte_cnt_d = byte_cnt_q + 32'($countones(tkeep_q));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pkt_cnt_q  <= 16'h0;
            byte_cnt_q <= 32'h0;
        end else begin
            pkt_cnt_q  <= pkt_cnt_d;
            byte_cnt_q <= byte_cnt_d;
        end
    end

    assign stat_pkt_count  = pkt_cnt_q;
    assign stat_byte_count = byte_cnt_q;
`endif

endmodule

// File: tb/tb_axis_byte_packer.sv
// Directed per-cycle vector bench for axis_byte_packer (default PAD_VALUE = 8'h00).
module tb_axis_byte_packer;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    axis_byte_packer_if bus();

`ifdef AXIS_PACKER_STATS_EN
    logic [15:0] stat_pkt;
    logic [31:0] stat_bytes;
`endif

    axis_byte_packer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef AXIS_PACKER_STATS_EN
        ,
        .stat_pkt_count  (stat_pkt),
        .stat_byte_count (stat_bytes)
`endif
    );

    typedef struct {
        logic        vld;
        logic [7:0]  data;
        logic        last;
        logic        ordy;
        logic        exp_irdy;
        logic        exp_ov;
        logic [31:0] exp_od;
        logic [3:0]  exp_keep;
        logic        exp_ol;
    } vec_t;

    vec_t vt[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic vec_t mk(logic v, logic [7:0] d, logic l, logic r,
                                logic ei, logic eo, logic [31:0] ed, logic [3:0] ek, logic el);
        vec_t x;
        x.vld = v; x.data = d; x.last = l; x.ordy = r;
        x.exp_irdy = ei; x.exp_ov = eo; x.exp_od = ed; x.exp_keep = ek; x.exp_ol = el;
        return x;
    endfunction

    // Drive one cycle of inputs, check ready before the edge and outputs after it.
    // Word fields are only compared when a valid word is expected.
    task automatic apply(input vec_t x, input string name);
        logic irdy;
        logic bad;
        bus.input_tvalid  = x.vld;
        bus.input_tdata   = x.data;
        bus.input_tlast   = x.last;
        bus.output_tready = x.ordy;
        #1;
        irdy = bus.input_tready;
        @(posedge clk);
        #1;
        n_vec++;
        bad = (irdy !== x.exp_irdy) || (bus.output_tvalid !== x.exp_ov);
        if (x.exp_ov)
            bad = bad || (bus.output_tdata !== x.exp_od) ||
                  (bus.output_tkeep !== x.exp_keep) || (bus.output_tlast !== x.exp_ol);
        if (bad) begin
            n_err++;
            $display("FAIL %s: got irdy=%b ov=%b od=%h keep=%h ol=%b, want irdy=%b ov=%b od=%h keep=%h ol=%b",
                     name, irdy, bus.output_tvalid, bus.output_tdata, bus.output_tkeep,
                     bus.output_tlast, x.exp_irdy, x.exp_ov, x.exp_od, x.exp_keep, x.exp_ol);
        end
    endtask

    // Hold reset for one cycle with a byte offered; everything must read zero.
    task automatic reset_cycle(input string name);
        logic irdy;
        reset             = 1'b1;
        bus.input_tvalid  = 1'b1;
        bus.input_tdata   = 8'h03;
        bus.input_tlast   = 1'b0;
        bus.output_tready = 1'b1;
        #1;
        irdy = bus.input_tready;
        @(posedge clk);
        #1;
        n_vec++;
        if (irdy !== 1'b0 || bus.output_tvalid !== 1'b0 || bus.output_tlast !== 1'b0 ||
            bus.output_tkeep !== 4'h0 || bus.output_tdata !== 32'h0) begin
            n_err++;
            $display("FAIL %s: got irdy=%b ov=%b od=%h keep=%h ol=%b, want all zero",
                     name, irdy, bus.output_tvalid, bus.output_tdata, bus.output_tkeep,
                     bus.output_tlast);
        end
    endtask

    initial begin
        reset             = 1'b1;
        bus.input_tvalid  = 1'b0;
        bus.input_tdata   = 8'h00;
        bus.input_tlast   = 1'b0;
        bus.output_tready = 1'b0;
        @(posedge clk);
        #1;
        reset_cycle("reset_state0");
        reset_cycle("reset_state1");
        reset = 1'b0;

        // 4-byte packet
        vt.push_back(mk(1, 8'h01, 0, 1, 1, 0, 32'h0, 4'h0, 0));
        vt.push_back(mk(1, 8'h02, 0, 1, 1, 0, 32'h0, 4'h0, 0));
        vt.push_back(mk(1, 8'h03, 0, 1, 1, 0, 32'h0, 4'h0, 0));
        vt.push_back(mk(1, 8'h04, 1, 1, 1, 1, 32'h04030201, 4'hF, 1));
        // 2-byte packet, padded
        vt.push_back(mk(1, 8'hAA, 0, 1, 1, 0, 32'h0, 4'h0, 0));
        vt.push_back(mk(1, 8'hBB, 1, 1, 1, 1, 32'h0000BBAA, 4'h3, 1));
        // 8 continuous bytes
        vt.push_back(mk(1, 8'h10, 0, 1, 1, 0, 32'h0, 4'h0, 0));
        vt.push_back(mk(1, 8'h11, 0, 1, 1, 0, 32'h0, 4'h0, 0));
        vt.push_back(mk(1, 8'h12, 0, 1, 1, 0, 32'h0, 4'h0, 0));
        vt.push_back(mk(1, 8'h13, 0, 1, 1, 1, 32'h13121110, 4'hF, 0));
        vt.push_back(mk(1, 8'h14, 0, 1, 1, 0, 32'h0, 4'h0, 0));
        vt.push_back(mk(1, 8'h15, 0, 1, 1, 0, 32'h0, 4'h0, 0));
        vt.push_back(mk(1, 8'h16, 0, 1, 1, 0, 32'h0, 4'h0, 0));
        vt.push_back(mk(1, 8'h17, 1, 1, 1, 1, 32'h17161514, 4'hF, 1));
        // 5-cycle stall; offered bytes must not be taken
        vt.push_back(mk(0, 8'h00, 0, 0, 0, 1, 32'h17161514, 4'hF, 1));
        vt.push_back(mk(1, 8'h55, 1, 0, 0, 1, 32'h17161514, 4'hF, 1));
        vt.push_back(mk(0, 8'h00, 0, 0, 0, 1, 32'h17161514, 4'hF, 1));
        vt.push_back(mk(1, 8'h55, 1, 0, 0, 1, 32'h17161514, 4'hF, 1));
        vt.push_back(mk(0, 8'h00, 0, 0, 0, 1, 32'h17161514, 4'hF, 1));
        vt.push_back(mk(0, 8'h00, 0, 1, 1, 0, 32'h0, 4'h0, 0));
        // back-to-back single-byte packets
        vt.push_back(mk(1, 8'h5A, 1, 1, 1, 1, 32'h0000005A, 4'h1, 1));
        vt.push_back(mk(1, 8'hC3, 1, 1, 1, 1, 32'h000000C3, 4'h1, 1));
        vt.push_back(mk(0, 8'h00, 0, 1, 1, 0, 32'h0, 4'h0, 0));
        // 3-byte packet into stalled sink, then resume mid-packet
        vt.push_back(mk(1, 8'h21, 0, 0, 1, 0, 32'h0, 4'h0, 0));
        vt.push_back(mk(1, 8'h22, 0, 0, 1, 0, 32'h0, 4'h0, 0));
        vt.push_back(mk(1, 8'h23, 1, 0, 1, 1, 32'h00232221, 4'h7, 1));
        vt.push_back(mk(1, 8'h24, 0, 0, 0, 1, 32'h00232221, 4'h7, 1));
        vt.push_back(mk(1, 8'h24, 0, 1, 1, 0, 32'h0, 4'h0, 0));
        vt.push_back(mk(1, 8'h25, 1, 1, 1, 1, 32'h00002524, 4'h3, 1));
        vt.push_back(mk(0, 8'h00, 0, 1, 1, 0, 32'h0, 4'h0, 0));

        for (int i = 0; i < vt.size(); i++) apply(vt[i], $sformatf("vec%0d", i));

        // Reset mid-packet discards bytes 01,02
        apply(mk(1, 8'h01, 0, 1, 1, 0, 32'h0, 4'h0, 0), "midrst_b0");
        apply(mk(1, 8'h02, 0, 1, 1, 0, 32'h0, 4'h0, 0), "midrst_b1");
        reset_cycle("midrst_reset");
        reset = 1'b0;
        apply(mk(1, 8'h05, 0, 1, 1, 0, 32'h0, 4'h0, 0), "midrst_p0");
        apply(mk(1, 8'h06, 0, 1, 1, 0, 32'h0, 4'h0, 0), "midrst_p1");
        apply(mk(1, 8'h07, 0, 1, 1, 0, 32'h0, 4'h0, 0), "midrst_p2");
        apply(mk(1, 8'h08, 1, 1, 1, 1, 32'h08070605, 4'hF, 1), "midrst_p3");
        // Reset drops a held word
        apply(mk(0, 8'h00, 0, 0, 0, 1, 32'h08070605, 4'hF, 1), "heldrst_hold");
        reset_cycle("heldrst_reset");
        reset = 1'b0;
        apply(mk(0, 8'h00, 0, 0, 1, 0, 32'h0, 4'h0, 0), "heldrst_after");

`ifdef AXIS_PACKER_STATS_EN
        reset_cycle("stats_reset");
        reset = 1'b0;
        for (int i = 6; i <= 13; i++) apply(vt[i], $sformatf("stats_c%0d", i));
        apply(mk(1, 8'hAA, 0, 1, 1, 0, 32'h0, 4'h0, 0), "stats_b0");
        apply(mk(1, 8'hBB, 1, 1, 1, 1, 32'h0000BBAA, 4'h3, 1), "stats_b1");
        apply(mk(0, 8'h00, 0, 1, 1, 0, 32'h0, 4'h0, 0), "stats_drain");
        n_vec++;
        if (stat_pkt !== 16'd2) begin
            n_err++;
            $display("FAIL stat_pkt_count: got %0d, want 2", stat_pkt);
        end
        n_vec++;
        if (stat_bytes !== 32'd10) begin
            n_err++;
            $display("FAIL stat_byte_count: got %0d, want 10", stat_bytes);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
